// File: rtl/pulser_pkg.sv
// Shared types and helpers for the debounced push-button pulser.
package pulser_pkg;

  // Per-channel pulse FSM states.
  typedef enum logic [1:0] {
    IDLE,
    HOLD_DELAY,
    HOLD_REPEAT
  } pulser_state_t;

  // Repeat-timer width: enough bits to count up to the larger of the two intervals minus one.
  function automatic int unsigned timerWidth(input int unsigned delay, input int unsigned period);
    int unsigned maxCyc;
    maxCyc = (delay > period) ? delay : period;
    return $clog2(maxCyc);
  endfunction

endpackage

// File: rtl/pulser_channel.sv
// One button channel: 2-FF synchroniser, counter debouncer and press/repeat pulse FSM.
module pulser_channel
  import pulser_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC  = 16,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = 64,
  parameter int unsigned REPEAT_PERIOD = 16
) (
  input  logic Clk,
  input  logic RstN,
  input  logic BtnIn,
  input  logic ModeRepeat,
  output logic BtnLevel,
  output logic PulseOut
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC);
  localparam int unsigned TimW = timerWidth(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CntW-1:0] CntLast    = CntW'(DEBOUNCE_CYC - 1);
  localparam logic [TimW-1:0] DelayLast  = TimW'(REPEAT_DELAY - 1);
  localparam logic [TimW-1:0] PeriodLast = TimW'(REPEAT_PERIOD - 1);

  logic            syncS1, syncS2;
  logic [CntW-1:0] cntQ, cntD;
  logic            levelD;
  logic [TimW-1:0] timerQ;
  pulser_state_t   stateQ;
  logic            repeatActive;

  // With REPEAT_EN=0 this is constant 0 and the HOLD_REPEAT path is pruned away.
  assign repeatActive = (REPEAT_EN != 0) && ModeRepeat;

  // Debounce next-state: level flips only after DEBOUNCE_CYC consecutive differing samples.
  always_comb begin
    cntD   = cntQ;
    levelD = BtnLevel;
    if (syncS2 == BtnLevel) begin
      cntD = '0;
    end else if (cntQ == CntLast) begin
      levelD = syncS2;
      cntD   = '0;
    end else begin
      cntD = cntQ + 1'b1;
    end
  end

  // Synchroniser and debounce state.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      syncS1   <= 1'b0;
      syncS2   <= 1'b0;
      cntQ     <= '0;
      BtnLevel <= 1'b0;
    end else begin
      syncS1   <= BtnIn;
      syncS2   <= syncS1;
      cntQ     <= cntD;
      BtnLevel <= levelD;
    end
  end

  // Pulse FSM; decisions use the next debounced level so the press pulse lands in the same
  // cycle BtnLevel first reads 1, and no repeat fires in the cycle the level drops.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      stateQ   <= IDLE;
      timerQ   <= '0;
      PulseOut <= 1'b0;
    end else begin
      PulseOut <= 1'b0;
      unique case (stateQ)
        IDLE: begin
          if (levelD && !BtnLevel) begin
            PulseOut <= 1'b1;
            timerQ   <= '0;
            stateQ   <= HOLD_DELAY;
          end
        end
        HOLD_DELAY: begin
          if (!levelD) begin
            stateQ <= IDLE;
          end else if (!repeatActive) begin
            timerQ <= '0;
          end else if (timerQ == DelayLast) begin
            PulseOut <= 1'b1;
            timerQ   <= '0;
            stateQ   <= HOLD_REPEAT;
          end else begin
            timerQ <= timerQ + 1'b1;
          end
        end
        HOLD_REPEAT: begin
          if (!levelD) begin
            stateQ <= IDLE;
          end else if (!repeatActive) begin
            timerQ <= '0;
            stateQ <= HOLD_DELAY;
          end else if (timerQ == PeriodLast) begin
            PulseOut <= 1'b1;
            timerQ   <= '0;
          end else begin
            timerQ <= timerQ + 1'b1;
          end
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/debounced_pulser.sv
// N_CH independent debounced push-button pulsers sharing clock, reset and repeat mode.
module debounced_pulser
  import pulser_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned DEBOUNCE_CYC  = 16,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = 64,
  parameter int unsigned REPEAT_PERIOD = 16
) (
  input  logic            Clk,
  input  logic            RstN,
  input  logic [N_CH-1:0] BtnIn,
  input  logic            ModeRepeat,
  output logic [N_CH-1:0] BtnLevel,
  output logic [N_CH-1:0] PulseOut
);

  if (N_CH < 1) begin : gChkNCh
    $error("debounced_pulser: N_CH must be >= 1");
  end
  if (DEBOUNCE_CYC < 2) begin : gChkDeb
    $error("debounced_pulser: DEBOUNCE_CYC must be >= 2");
  end
  if (REPEAT_DELAY < 2) begin : gChkDelay
    $error("debounced_pulser: REPEAT_DELAY must be >= 2");
  end
  if (REPEAT_PERIOD < 2) begin : gChkPeriod
    $error("debounced_pulser: REPEAT_PERIOD must be >= 2");
  end

  for (genvar i = 0; i < N_CH; i++) begin : gChan
    pulser_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) uChan (
      .Clk       (Clk),
      .RstN      (RstN),
      .BtnIn     (BtnIn[i]),
      .ModeRepeat(ModeRepeat),
      .BtnLevel  (BtnLevel[i]),
      .PulseOut  (PulseOut[i])
    );
  end

endmodule
